trap_sequencer: RTL and testbench

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

---
 rtl/trap_sequencer_pkg.sv | 47 ++++
 rtl/trap_sequencer_if.sv | 29 ++
 rtl/trap_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_trap_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_sequencer_pkg.sv
// Shared CSR definitions for the trap sequencer: privilege encodings, CSR
// addresses, mstatus bit positions and exception cause codes.
// Optional feature macro: TRAP_S_MODE_EN (supervisor mode, delegation, SRET).
package trap_sequencer_pkg;

    // Privilege mode encodings
    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    // Trap CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;

    // mstatus field bit positions
    localparam int MSTATUS_SIE    = 1;
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_SPIE   = 5;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_SPP    = 8;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Exception cause codes
    localparam logic [4:0] CAUSE_MISALIGNED_FETCH = 5'd0;
    localparam logic [4:0] CAUSE_ILLEGAL_INSTR    = 5'd2;
    localparam logic [4:0] CAUSE_BREAKPOINT       = 5'd3;
    localparam logic [4:0] CAUSE_LOAD_FAULT       = 5'd5;
    localparam logic [4:0] CAUSE_ECALL_U          = 5'd8;
    localparam logic [4:0] CAUSE_ECALL_S          = 5'd9;
    localparam logic [4:0] CAUSE_ECALL_M          = 5'd11;

    // Without supervisor mode, an MPP of S is not representable and collapses to U
    function automatic logic [1:0] legalizeMpp(input logic [1:0] priv);
`ifdef TRAP_S_MODE_EN
        return priv;
`else
        return (priv == PRIV_S) ? PRIV_U : priv;
`endif
    endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Trap event / fetch redirect bus between the pipeline and the trap sequencer.
// The slave side is the sequencer; the master side is the pipeline and fetch.
interface trap_sequencer_if #(
    parameter int XLEN = 32
);
    logic            exc_valid;
    logic [4:0]      exc_code;
    logic [XLEN-1:0] exc_pc;
    logic [XLEN-1:0] exc_val;
    logic            mret_valid;
    logic            sret_valid;
    logic            redirect_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic            busy;

    modport master (
        output exc_valid, exc_code, exc_pc, exc_val, mret_valid, sret_valid,
        output redirect_ready,
        input  redirect_valid, redirect_pc, flush, busy
    );

    modport slave (
        input  exc_valid, exc_code, exc_pc, exc_val, mret_valid, sret_valid,
        input  redirect_ready,
        output redirect_valid, redirect_pc, flush, busy
    );
endinterface

// File: rtl/trap_sequencer.sv
// Trap sequencer: captures exceptions and xRET events, updates the trap CSRs
// and privilege, flushes the pipeline for one cycle and then holds a fetch
// redirect until fetch accepts it.
// Optional feature macro: TRAP_S_MODE_EN enables S-mode CSRs, delegation
// through medeleg and SRET; without it every trap goes to M-mode.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int         XLEN       = 32,
    parameter logic [1:0] RESET_PRIV = 2'b11
) (
    input  logic            clk,
    input  logic            reset,
    trap_sequencer_if.slave bus,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] stvec,
    input  logic [31:0]     medeleg,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [1:0]      current_priv,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mtval,
    output logic [XLEN-1:0] sepc,
    output logic [XLEN-1:0] scause,
    output logic [XLEN-1:0] stval,
    output logic            mstatus_mie,
    output logic            mstatus_mpie,
    output logic [1:0]      mstatus_mpp,
    output logic            mstatus_sie,
    output logic            mstatus_spie,
    output logic            mstatus_spp
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t          r_state;
    logic [1:0]      r_priv;
    logic            r_flush;
    logic            r_redirectValid;
    logic [XLEN-1:0] r_redirectPc;
    logic            r_busy;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic            r_mie;
    logic            r_mpie;
    logic [1:0]      r_mpp;
`ifdef TRAP_S_MODE_EN
    logic [XLEN-1:0] r_sepc;
    logic [XLEN-1:0] r_scause;
    logic [XLEN-1:0] r_stval;
    logic            r_sie;
    logic            r_spie;
    logic            r_spp;
`endif

    logic            w_delegate;
    logic            w_sretFire;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_epc;
    logic            w_unused;

    assign w_cause = {{(XLEN-5){1'b0}}, bus.exc_code};
    assign w_epc   = {bus.exc_pc[XLEN-1:1], 1'b0};

`ifdef TRAP_S_MODE_EN
    assign w_delegate = (r_priv != PRIV_M) && medeleg[bus.exc_code];
    assign w_sretFire = bus.sret_valid;
    assign w_unused   = ^{bus.exc_pc[0], mtvec[1:0], stvec[1:0]};
`else
    assign w_delegate = 1'b0;
    assign w_sretFire = 1'b0;
    assign w_unused   = ^{bus.exc_pc[0], mtvec[1:0], stvec, medeleg, bus.sret_valid};
`endif

    // Sequencer FSM plus trap CSR state; software writes are applied first so
    // that a trap or xRET capture in the same cycle overrides them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_priv          <= RESET_PRIV;
            r_flush         <= 1'b0;
            r_redirectValid <= 1'b0;
            r_redirectPc    <= '0;
            r_busy          <= 1'b0;
            r_mepc          <= '0;
            r_mcause        <= '0;
            r_mtval         <= '0;
            r_mie           <= 1'b0;
            r_mpie          <= 1'b0;
            r_mpp           <= 2'b00;
`ifdef TRAP_S_MODE_EN
            r_sepc          <= '0;
            r_scause        <= '0;
            r_stval         <= '0;
            r_sie           <= 1'b0;
            r_spie          <= 1'b0;
            r_spp           <= 1'b0;
`endif
        end else begin
            if (csr_we) begin
                case (csr_addr)
                    CSR_MEPC:   r_mepc   <= {csr_wdata[XLEN-1:1], 1'b0};
                    CSR_MCAUSE: r_mcause <= csr_wdata;
                    CSR_MTVAL:  r_mtval  <= csr_wdata;
`ifdef TRAP_S_MODE_EN
                    CSR_SEPC:   r_sepc   <= {csr_wdata[XLEN-1:1], 1'b0};
                    CSR_SCAUSE: r_scause <= csr_wdata;
                    CSR_STVAL:  r_stval  <= csr_wdata;
`endif
                    CSR_MSTATUS: begin
                        r_mie  <= csr_wdata[MSTATUS_MIE];
                        r_mpie <= csr_wdata[MSTATUS_MPIE];
                        r_mpp  <= legalizeMpp(csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
`ifdef TRAP_S_MODE_EN
                        r_sie  <= csr_wdata[MSTATUS_SIE];
                        r_spie <= csr_wdata[MSTATUS_SPIE];
                        r_spp  <= csr_wdata[MSTATUS_SPP];
`endif
                    end
                    default: ;
                endcase
            end

            case (r_state)
                IDLE: begin
                    if (bus.exc_valid || bus.mret_valid || w_sretFire) begin
                        r_state <= FLUSH;
                        r_flush <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                    if (bus.exc_valid) begin
                        if (w_delegate) begin
`ifdef TRAP_S_MODE_EN
                            r_sepc       <= w_epc;
                            r_scause     <= w_cause;
                            r_stval      <= bus.exc_val;
                            r_spie       <= r_sie;
                            r_sie        <= 1'b0;
                            r_spp        <= r_priv[0];
                            r_priv       <= PRIV_S;
                            r_redirectPc <= {stvec[XLEN-1:2], 2'b00};
`endif
                        end else begin
                            r_mepc       <= w_epc;
                            r_mcause     <= w_cause;
                            r_mtval      <= bus.exc_val;
                            r_mpie       <= r_mie;
                            r_mie        <= 1'b0;
                            r_mpp        <= legalizeMpp(r_priv);
                            r_priv       <= PRIV_M;
                            r_redirectPc <= {mtvec[XLEN-1:2], 2'b00};
                        end
                    end else if (bus.mret_valid) begin
                        r_priv       <= r_mpp;
                        r_mie        <= r_mpie;
                        r_mpie       <= 1'b1;
                        r_mpp        <= PRIV_U;
                        r_redirectPc <= r_mepc;
                    end else if (w_sretFire) begin
`ifdef TRAP_S_MODE_EN
                        r_priv       <= {1'b0, r_spp};
                        r_sie        <= r_spie;
                        r_spie       <= 1'b1;
                        r_spp        <= 1'b0;
                        r_redirectPc <= r_sepc;
`endif
                    end
                end
                FLUSH: begin
                    r_flush         <= 1'b0;
                    r_redirectValid <= 1'b1;
                    r_state         <= REDIRECT;
                end
                REDIRECT: begin
                    if (bus.redirect_ready) begin
                        r_redirectValid <= 1'b0;
                        r_busy          <= 1'b0;
                        r_state         <= IDLE;
                    end
                end
                default: begin
                    r_flush         <= 1'b0;
                    r_redirectValid <= 1'b0;
                    r_busy          <= 1'b0;
                    r_state         <= IDLE;
                end
            endcase
        end
    end

    assign bus.flush          = r_flush;
    assign bus.redirect_valid = r_redirectValid;
    assign bus.redirect_pc    = r_redirectPc;
    assign bus.busy           = r_busy;
    assign current_priv       = r_priv;
    assign mepc               = r_mepc;
    assign mcause             = r_mcause;
    assign mtval              = r_mtval;
    assign mstatus_mie        = r_mie;
    assign mstatus_mpie       = r_mpie;
    assign mstatus_mpp        = r_mpp;
`ifdef TRAP_S_MODE_EN
    assign sepc               = r_sepc;
    assign scause             = r_scause;
    assign stval              = r_stval;
    assign mstatus_sie        = r_sie;
    assign mstatus_spie       = r_spie;
    assign mstatus_spp        = r_spp;
`else
    assign sepc               = '0;
    assign scause             = '0;
    assign stval              = '0;
    assign mstatus_sie        = 1'b0;
    assign mstatus_spie       = 1'b0;
    assign mstatus_spp        = 1'b0;
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// Testbench for trap_sequencer: a table of trap vectors plus hand-written
// sequences for back-pressure, MRET/SRET, capture collisions and reset abort.
// Redirects are checked by a scoreboard fed whenever an event is driven.
module tb_trap_sequencer;
    import trap_sequencer_pkg::*;

    localparam logic [31:0] MTVEC = 32'h8000_0201;
    localparam logic [31:0] STVEC = 32'h8000_3005;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  priv;
    } expect_t;

    typedef struct {
        string       name;
        logic [1:0]  startPriv;
        logic [4:0]  code;
        logic [31:0] pc;
        logic [31:0] val;
        logic [31:0] deleg;
        logic        toS;
        logic [1:0]  expPriv;
        logic [31:0] expPc;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] mtvec;
    logic [31:0] stvec;
    logic [31:0] medeleg;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [1:0]  current_priv;
    logic [31:0] mepc, mcause, mtval, sepc, scause, stval;
    logic        mstatus_mie, mstatus_mpie, mstatus_sie, mstatus_spie, mstatus_spp;
    logic [1:0]  mstatus_mpp;

    int      errors = 0;
    int      checks = 0;
    expect_t expQ[$];
    vec_t    vecs[6];

    trap_sequencer_if #(.XLEN(32)) bus ();

    trap_sequencer #(.XLEN(32), .RESET_PRIV(2'b11)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .mtvec        (mtvec),
        .stvec        (stvec),
        .medeleg      (medeleg),
        .csr_we       (csr_we),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .current_priv (current_priv),
        .mepc         (mepc),
        .mcause       (mcause),
        .mtval        (mtval),
        .sepc         (sepc),
        .scause       (scause),
        .stval        (stval),
        .mstatus_mie  (mstatus_mie),
        .mstatus_mpie (mstatus_mpie),
        .mstatus_mpp  (mstatus_mpp),
        .mstatus_sie  (mstatus_sie),
        .mstatus_spie (mstatus_spie),
        .mstatus_spp  (mstatus_spp)
    );

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExpect(input logic [31:0] pc, input logic [1:0] priv);
        expect_t e;
        e.pc   = pc;
        e.priv = priv;
        expQ.push_back(e);
    endtask

    task automatic csrWrite(input logic [11:0] addr, input logic [31:0] data);
        csr_we    = 1'b1;
        csr_addr  = addr;
        csr_wdata = data;
        tick();
        csr_we    = 1'b0;
    endtask

    // Drive one event for a single cycle; returns in the cycle after capture
    task automatic applyStimulus(input logic exc, input logic mret, input logic sret,
                                 input logic [4:0] code, input logic [31:0] pc, input logic [31:0] val);
        bus.exc_valid  = exc;
        bus.mret_valid = mret;
        bus.sret_valid = sret;
        bus.exc_code   = code;
        bus.exc_pc     = pc;
        bus.exc_val    = val;
        tick();
        bus.exc_valid  = 1'b0;
        bus.mret_valid = 1'b0;
        bus.sret_valid = 1'b0;
        csr_we         = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        for (int i = 0; i < 20 && bus.busy; i++) tick();
        checkOutput({name, " returns idle"}, bus.busy, 1'b0);
    endtask

    function automatic logic [1:0] legalPriv(input logic [1:0] p);
`ifdef TRAP_S_MODE_EN
        return p;
`else
        return (p == PRIV_S) ? PRIV_U : p;
`endif
    endfunction

    // Reach a privilege level through an MRET; leaves MIE=MPIE=1, SIE=1, MPP=U
    task automatic setPriv(input logic [1:0] p);
        csrWrite(CSR_MSTATUS, (32'(p) << 11) | 32'h0000_0082);
        csrWrite(CSR_MEPC, 32'h8000_1000);
        pushExpect(32'h8000_1000, legalPriv(p));
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
        checkOutput("setPriv priv", current_priv, legalPriv(p));
        waitIdle("setPriv");
    endtask

    // Scoreboard: every accepted redirect consumes the oldest expectation
    always @(negedge clk) begin
        if (!reset && bus.redirect_valid && bus.redirect_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected redirect: got pc 0x%0h, expected no redirect", bus.redirect_pc);
            end else begin
                expect_t e;
                e = expQ.pop_front();
                checkOutput("scoreboard redirect_pc", bus.redirect_pc, e.pc);
                checkOutput("scoreboard priv", current_priv, e.priv);
            end
        end
    end

    initial begin
        vecs[0] = '{"illegal from M", 2'b11, CAUSE_ILLEGAL_INSTR, 32'h8000_0104, 32'h0000_0073,
                    32'h0, 1'b0, 2'b11, 32'h8000_0200};
`ifdef TRAP_S_MODE_EN
        vecs[1] = '{"delegated ecall U", 2'b00, CAUSE_ECALL_U, 32'h8000_0500, 32'h0,
                    32'h0000_0100, 1'b1, 2'b01, 32'h8000_3004};
`else
        vecs[1] = '{"delegated ecall U", 2'b00, CAUSE_ECALL_U, 32'h8000_0500, 32'h0,
                    32'h0000_0100, 1'b0, 2'b11, 32'h8000_0200};
`endif
        vecs[2] = '{"odd pc from M", 2'b11, CAUSE_MISALIGNED_FETCH, 32'h8000_0203, 32'h8000_0203,
                    32'h0000_0001, 1'b0, 2'b11, 32'h8000_0200};
        vecs[3] = '{"ecall U no deleg", 2'b00, CAUSE_ECALL_U, 32'h8000_0610, 32'h0,
                    32'h0, 1'b0, 2'b11, 32'h8000_0200};
        vecs[4] = '{"load fault U other deleg", 2'b00, CAUSE_LOAD_FAULT, 32'h8000_0720, 32'h1234_5678,
                    32'h0000_0100, 1'b0, 2'b11, 32'h8000_0200};
        vecs[5] = '{"breakpoint M full deleg", 2'b11, CAUSE_BREAKPOINT, 32'h8000_0830, 32'h8000_0830,
                    32'hFFFF_FFFF, 1'b0, 2'b11, 32'h8000_0200};

        reset          = 1'b1;
        mtvec          = MTVEC;
        stvec          = STVEC;
        medeleg        = 32'h0;
        csr_we         = 1'b0;
        csr_addr       = 12'h0;
        csr_wdata      = 32'h0;
        bus.exc_valid  = 1'b0;
        bus.exc_code   = 5'd0;
        bus.exc_pc     = 32'h0;
        bus.exc_val    = 32'h0;
        bus.mret_valid = 1'b0;
        bus.sret_valid = 1'b0;
        bus.redirect_ready = 1'b1;

        // Reset values
        repeat (3) tick();
        checkOutput("reset flush", bus.flush, 1'b0);
        checkOutput("reset redirect_valid", bus.redirect_valid, 1'b0);
        checkOutput("reset redirect_pc", bus.redirect_pc, 32'h0);
        checkOutput("reset busy", bus.busy, 1'b0);
        checkOutput("reset priv", current_priv, 2'b11);
        checkOutput("reset mepc", mepc, 32'h0);
        checkOutput("reset mcause", mcause, 32'h0);
        checkOutput("reset mtval", mtval, 32'h0);
        checkOutput("reset sepc", sepc, 32'h0);
        checkOutput("reset mstatus", {mstatus_mie, mstatus_mpie, mstatus_mpp, mstatus_sie,
                                      mstatus_spie, mstatus_spp}, 7'h0);
        reset = 1'b0;
        tick();

        // Table of trap vectors
        for (int i = 0; i < 6; i++) begin
            vec_t v;
            v = vecs[i];
            setPriv(v.startPriv);
            medeleg = v.deleg;
            pushExpect(v.expPc, v.expPriv);
            applyStimulus(1'b1, 1'b0, 1'b0, v.code, v.pc, v.val);
            checkOutput({v.name, " flush"}, bus.flush, 1'b1);
            checkOutput({v.name, " busy"}, bus.busy, 1'b1);
            checkOutput({v.name, " priv"}, current_priv, v.expPriv);
            if (v.toS) begin
                checkOutput({v.name, " sepc"}, sepc, v.pc & 32'hFFFF_FFFE);
                checkOutput({v.name, " scause"}, scause, 32'(v.code));
                checkOutput({v.name, " stval"}, stval, v.val);
                checkOutput({v.name, " spp"}, mstatus_spp, v.startPriv[0]);
                checkOutput({v.name, " sie/spie"}, {mstatus_sie, mstatus_spie}, 2'b01);
            end else begin
                checkOutput({v.name, " mepc"}, mepc, v.pc & 32'hFFFF_FFFE);
                checkOutput({v.name, " mcause"}, mcause, 32'(v.code));
                checkOutput({v.name, " mtval"}, mtval, v.val);
                checkOutput({v.name, " mpp"}, mstatus_mpp, v.startPriv);
                checkOutput({v.name, " mie/mpie"}, {mstatus_mie, mstatus_mpie}, 2'b01);
            end
            tick();
            checkOutput({v.name, " redirect_valid N+2"}, bus.redirect_valid, 1'b1);
            waitIdle(v.name);
            medeleg = 32'h0;
        end

        // Back-pressure: redirect held while ready is low, events ignored
        setPriv(2'b11);
        bus.redirect_ready = 1'b0;
        pushExpect(32'h8000_0200, 2'b11);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd7, 32'h8000_0600, 32'h44);
        checkOutput("bp flush", bus.flush, 1'b1);
        tick();
        checkOutput("bp flush drops", bus.flush, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                bus.exc_valid  = 1'b1;
                bus.mret_valid = 1'b1;
                bus.exc_pc     = 32'h9000_0000;
                bus.exc_code   = 5'd3;
            end
            if (k == 3) begin
                csr_we    = 1'b1;
                csr_addr  = CSR_MTVAL;
                csr_wdata = 32'hDEAD_BEEF;
            end
            tick();
            bus.exc_valid  = 1'b0;
            bus.mret_valid = 1'b0;
            csr_we         = 1'b0;
            checkOutput("bp redirect_valid", bus.redirect_valid, 1'b1);
            checkOutput("bp redirect_pc", bus.redirect_pc, 32'h8000_0200);
            checkOutput("bp busy", bus.busy, 1'b1);
        end
        checkOutput("bp ignored exc mepc", mepc, 32'h8000_0600);
        checkOutput("bp csr write mtval", mtval, 32'hDEAD_BEEF);
        bus.redirect_ready = 1'b1;
        waitIdle("bp");

        // Software mepc writes always clear bit 0
        csrWrite(CSR_MEPC, 32'h8000_0777);
        checkOutput("mepc bit0 forced", mepc, 32'h8000_0776);

        // MRET back to the mode held in MPP
        csrWrite(CSR_MSTATUS, 32'h0000_0880);
        checkOutput("mpp write 01", mstatus_mpp, legalPriv(2'b01));
        csrWrite(CSR_MEPC, 32'h8000_0400);
        pushExpect(32'h8000_0400, legalPriv(2'b01));
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
        checkOutput("mret priv", current_priv, legalPriv(2'b01));
        checkOutput("mret mie/mpie/mpp", {mstatus_mie, mstatus_mpie, mstatus_mpp}, 4'b1100);
        waitIdle("mret");

`ifdef TRAP_S_MODE_EN
        // SRET from S back to U
        csrWrite(CSR_MSTATUS, 32'h0000_0020);
        csrWrite(CSR_SEPC, 32'h8000_0901);
        checkOutput("sepc bit0 forced", sepc, 32'h8000_0900);
        pushExpect(32'h8000_0900, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h0);
        checkOutput("sret priv", current_priv, 2'b00);
        checkOutput("sret sie/spie/spp", {mstatus_sie, mstatus_spie, mstatus_spp}, 3'b110);
        waitIdle("sret");
`else
        // SRET and S-mode CSRs are absent
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h0);
        checkOutput("sret ignored busy", bus.busy, 1'b0);
        csrWrite(CSR_SEPC, 32'h8000_0900);
        checkOutput("sepc reads zero", sepc, 32'h0);
`endif

        // Simultaneous trap and MRET, with a colliding mepc write
        setPriv(2'b11);
        pushExpect(32'h8000_0200, 2'b11);
        csr_we    = 1'b1;
        csr_addr  = CSR_MEPC;
        csr_wdata = 32'h1234_5678;
        applyStimulus(1'b1, 1'b1, 1'b0, CAUSE_ECALL_M, 32'h8000_0800, 32'h0);
        checkOutput("collide mepc", mepc, 32'h8000_0800);
        checkOutput("collide mcause", mcause, 32'(CAUSE_ECALL_M));
        checkOutput("collide priv", current_priv, 2'b11);
        checkOutput("collide mpp", mstatus_mpp, 2'b11);
        waitIdle("collide");

        // Reset in the middle of a redirect aborts it
        setPriv(2'b00);
        bus.redirect_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, CAUSE_ILLEGAL_INSTR, 32'h8000_0104, 32'h73);
        tick();
        checkOutput("abort in redirect", bus.redirect_valid, 1'b1);
        reset = 1'b1;
        tick();
        checkOutput("abort redirect_valid", bus.redirect_valid, 1'b0);
        checkOutput("abort busy", bus.busy, 1'b0);
        checkOutput("abort priv", current_priv, 2'b11);
        checkOutput("abort mepc", mepc, 32'h0);
        reset = 1'b0;
        bus.redirect_ready = 1'b1;
        repeat (3) tick();
        checkOutput("abort no redirect", {bus.redirect_valid, bus.busy, bus.flush}, 3'b000);

        tick();
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
